// File: rtl/fm7_subif_pkg.sv
// Shared definitions for the FM-7 sub-CPU interface ($FD05).
// Halt FSM encoding and the fixed bits of the status byte.
package fm7_subif_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REQ    = 2'd1,
        ST_HALTED = 2'd2,
        ST_REL    = 2'd3
    } halt_st_t;

    localparam logic [4:0] DOUT_ONES = 5'b11111;

    function automatic logic [7:0] pack_dout(
        input logic busy,
        input logic err,
        input logic halted
    );
        return {busy, err, DOUT_ONES, halted};
    endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Fixed-width active-low pulse generator.
// Triggers arriving while a pulse is running are dropped.
module pulse_stretch #(
    parameter int unsigned CANCEL_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_trig,
    output logic o_pulse_n
);

    localparam logic [7:0] LEN_V = 8'(CANCEL_LEN);

    logic [7:0] r_cnt;

    // Load on an idle trigger, then count the low phase down to zero
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= 8'd0;
        end else if (r_cnt == 8'd0) begin
            if (i_trig) begin
                r_cnt <= LEN_V;
            end
        end else begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_pulse_n = (r_cnt == 8'd0);

endmodule

// File: rtl/main_sub_if.sv
// Main-CPU side of the sub-CPU control register ($FD05):
// halt handshake FSM, ack timeout, cancel pulse and status read.
module main_sub_if
    import fm7_subif_pkg::*;
#(
    parameter int unsigned CANCEL_LEN  = 8,
    parameter int unsigned ACK_TIMEOUT = 4095
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CS_FD05,
    input  logic       RW,
    input  logic       WR_STB,
    input  logic [7:0] DIN,
    output logic [7:0] DOUT,
    input  logic       SHALTACn,
    input  logic       BUSY,
    output logic       SUBHALTREQn,
    output logic       CANCELn,
    output logic       SHRAM_GNT,
    output logic       ACK_ERR
);

    localparam logic [16:0] TMO = 17'(ACK_TIMEOUT);

    logic        r_shac_s1;
    logic        r_shac_s2;
    logic        r_busy_s1;
    logic        r_busy_s2;
    logic        r_halt_want;
    logic [15:0] r_cnt;
    logic        r_ack_err;
    halt_st_t    r_state;
    halt_st_t    w_state_nxt;

    logic        w_wr;
    logic        w_rd;
    logic        w_cnt_hit;
    logic [15:0] w_cnt_inc;
    logic        w_set_err;
    logic        w_clr_cnt;
    logic        w_unused;

    assign w_wr      = CS_FD05 & ~RW & WR_STB;
    assign w_rd      = CS_FD05 & RW;
    assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    assign w_cnt_hit = (({1'b0, r_cnt} + 17'd1) == TMO);
    assign w_unused  = ^DIN[5:0];

    // Two-flop synchronizers for the asynchronous sub-CPU status lines
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_shac_s1 <= 1'b1;
            r_shac_s2 <= 1'b1;
            r_busy_s1 <= 1'b0;
            r_busy_s2 <= 1'b0;
        end else begin
            r_shac_s1 <= SHALTACn;
            r_shac_s2 <= r_shac_s1;
            r_busy_s1 <= BUSY;
            r_busy_s2 <= r_busy_s1;
        end
    end

    // HALT_WANT follows bit 7 of each register write
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_halt_want <= 1'b0;
        end else if (w_wr) begin
            r_halt_want <= DIN[7];
        end
    end

    // Halt FSM state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Halt FSM transitions; an ack beats a withdraw, which beats a timeout
    always_comb begin
        w_state_nxt = r_state;
        w_set_err   = 1'b0;
        w_clr_cnt   = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (r_halt_want) begin
                    w_state_nxt = ST_REQ;
                    w_clr_cnt   = 1'b1;
                end
            end
            ST_REQ: begin
                if (!r_shac_s2) begin
                    w_state_nxt = ST_HALTED;
                end else if (!r_halt_want) begin
                    w_state_nxt = ST_REL;
                end else if (w_cnt_hit) begin
                    w_state_nxt = ST_REL;
                    w_set_err   = 1'b1;
                end
            end
            ST_HALTED: begin
                if (!r_halt_want) begin
                    w_state_nxt = ST_REL;
                end
            end
            ST_REL: begin
                if (r_shac_s2) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Saturating ack-wait counter, restarted on each entry to REQ
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt <= 16'd0;
        end else if (w_clr_cnt) begin
            r_cnt <= 16'd0;
        end else if (r_state == ST_REQ) begin
            r_cnt <= w_cnt_inc;
        end
    end

    // Sticky timeout flag; a fresh timeout outranks a clearing read
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ack_err <= 1'b0;
        end else if (w_set_err) begin
            r_ack_err <= 1'b1;
        end else if (w_rd) begin
            r_ack_err <= 1'b0;
        end
    end

    pulse_stretch #(
        .CANCEL_LEN(CANCEL_LEN)
    ) u_cancel (
        .i_clk    (CLK),
        .i_rst    (RESET),
        .i_trig   (w_wr & DIN[6]),
        .o_pulse_n(CANCELn)
    );

    assign SUBHALTREQn = ~((r_state == ST_REQ) | (r_state == ST_HALTED));
    assign SHRAM_GNT   = (r_state == ST_HALTED);
    assign ACK_ERR     = r_ack_err;
    assign DOUT        = pack_dout(r_busy_s2, r_ack_err,
                                   r_state == ST_HALTED);

endmodule

// File: tb/tb_main_sub_if.sv
// Self-checking bench for main_sub_if: cycle table, directed
// corner sequences and a randomized cancel/BUSY model.
module tb_main_sub_if;

    localparam int LEN = 8;
    localparam int TMO = 20;

    logic       CLK;
    logic       RESET;
    logic       CS_FD05;
    logic       RW;
    logic       WR_STB;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic       SHALTACn;
    logic       BUSY;
    logic       SUBHALTREQn;
    logic       CANCELn;
    logic       SHRAM_GNT;
    logic       ACK_ERR;

    int n_chk  = 0;
    int n_pass = 0;

    main_sub_if #(
        .CANCEL_LEN (LEN),
        .ACK_TIMEOUT(TMO)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .CS_FD05    (CS_FD05),
        .RW         (RW),
        .WR_STB     (WR_STB),
        .DIN        (DIN),
        .DOUT       (DOUT),
        .SHALTACn   (SHALTACn),
        .BUSY       (BUSY),
        .SUBHALTREQn(SUBHALTREQn),
        .CANCELn    (CANCELn),
        .SHRAM_GNT  (SHRAM_GNT),
        .ACK_ERR    (ACK_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic       shac;
        logic       e_shn;
        logic       e_cn;
        logic       e_gnt;
        logic [7:0] e_dout;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(
        input logic wr, input logic [7:0] din, input logic shac,
        input logic shn, input logic cn, input logic gnt,
        input logic [7:0] dout
    );
        vec_t v;
        v.wr = wr; v.din = din; v.shac = shac;
        v.e_shn = shn; v.e_cn = cn; v.e_gnt = gnt; v.e_dout = dout;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)",
                      name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        CS_FD05 = 1'b0; RW = 1'b1; WR_STB = 1'b0; DIN = 8'h00;
    endtask

    task automatic wr_reg(input logic [7:0] d);
        CS_FD05 = 1'b1; RW = 1'b0; WR_STB = 1'b1; DIN = d;
    endtask

    task automatic rd_reg();
        CS_FD05 = 1'b1; RW = 1'b1; WR_STB = 1'b0; DIN = 8'h00;
    endtask

    // Halt request with no ack; optionally read on the timeout edge
    task automatic run_timeout(input bit rd_at_hit);
        SHALTACn = 1'b1;
        wr_reg(8'h80);
        tick();
        idle();
        chk("to_shn_c0", SUBHALTREQn, 1'b1);
        for (int k = 1; k <= TMO; k++) begin
            tick();
            if (k == 1) chk("to_shn_c1", SUBHALTREQn, 1'b0);
        end
        chk("to_err_c20", ACK_ERR, 1'b0);
        chk("to_shn_c20", SUBHALTREQn, 1'b0);
        if (rd_at_hit) rd_reg();
        tick();
        idle();
        chk("to_err_c21", ACK_ERR, 1'b1);
        chk("to_rel_shn", SUBHALTREQn, 1'b1);
        chk("to_dout", DOUT, 8'h7E);
        wr_reg(8'h00);
        tick();
        chk("to_sticky", ACK_ERR, 1'b1);
        rd_reg();
        tick();
        idle();
        chk("to_clr_err", ACK_ERR, 1'b0);
        chk("to_clr_dout", DOUT, 8'h3E);
        tick();
        chk("to_stay_run", SUBHALTREQn, 1'b1);
    endtask

    initial begin
        int lows;
        int falls;
        logic prev;
        int last_start;
        logic bprev;
        logic exp7;
        logic exp_cn;
        logic trig;

        RESET = 1'b1; SHALTACn = 1'b1; BUSY = 1'b0;
        idle();
        #2;
        chk("rst_shn", SUBHALTREQn, 1'b1);
        chk("rst_cn", CANCELn, 1'b1);
        chk("rst_gnt", SHRAM_GNT, 1'b0);
        chk("rst_err", ACK_ERR, 1'b0);
        chk("rst_dout", DOUT, 8'h3E);
        #20 RESET = 1'b0;
        tick();
        tick();

        // Halt+cancel in one write, ack, release, re-request from REL
        tbl[0]  = mk(1, 8'hC0, 1, 1, 0, 0, 8'h3E);
        tbl[1]  = mk(0, 8'h00, 1, 0, 0, 0, 8'h3E);
        tbl[2]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h3E);
        tbl[3]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h3E);
        tbl[4]  = mk(0, 8'h00, 0, 0, 0, 1, 8'h3F);
        tbl[5]  = mk(0, 8'h00, 0, 0, 0, 1, 8'h3F);
        tbl[6]  = mk(0, 8'h00, 0, 0, 0, 1, 8'h3F);
        tbl[7]  = mk(0, 8'h00, 0, 0, 0, 1, 8'h3F);
        tbl[8]  = mk(1, 8'h00, 0, 0, 1, 1, 8'h3F);
        tbl[9]  = mk(0, 8'h00, 0, 1, 1, 0, 8'h3E);
        tbl[10] = mk(1, 8'h80, 1, 1, 1, 0, 8'h3E);
        tbl[11] = mk(0, 8'h00, 1, 1, 1, 0, 8'h3E);
        tbl[12] = mk(0, 8'h00, 1, 1, 1, 0, 8'h3E);
        tbl[13] = mk(0, 8'h00, 1, 0, 1, 0, 8'h3E);
        tbl[14] = mk(1, 8'h00, 1, 0, 1, 0, 8'h3E);
        tbl[15] = mk(0, 8'h00, 1, 1, 1, 0, 8'h3E);
        tbl[16] = mk(0, 8'h00, 1, 1, 1, 0, 8'h3E);
        for (int i = 0; i < 17; i++) begin
            if (tbl[i].wr) wr_reg(tbl[i].din);
            else idle();
            SHALTACn = tbl[i].shac;
            tick();
            chk($sformatf("tbl%0d_shn", i), SUBHALTREQn, tbl[i].e_shn);
            chk($sformatf("tbl%0d_cn", i), CANCELn, tbl[i].e_cn);
            chk($sformatf("tbl%0d_gnt", i), SHRAM_GNT, tbl[i].e_gnt);
            chk($sformatf("tbl%0d_dout", i), DOUT, tbl[i].e_dout);
        end
        idle();
        SHALTACn = 1'b1;
        tick();

        run_timeout(1'b0);
        run_timeout(1'b1);

        // Retrigger during an active pulse must not extend it
        lows = 0; falls = 0; prev = 1'b1;
        for (int e = 0; e < 20; e++) begin
            if (e == 0 || e == 3) wr_reg(8'h40);
            else idle();
            tick();
            if (CANCELn == 1'b0) lows++;
            if (prev && !CANCELn) falls++;
            prev = CANCELn;
        end
        chk("cancel_len", 8'(lows), 8'(LEN));
        chk("cancel_falls", 8'(falls), 8'd1);

        // BUSY rises mid-cycle
        #3 BUSY = 1'b1;
        for (int e = 0; e < 2; e++) begin
            tick();
            chk("busy_ones", {3'b000, DOUT[5:1]}, 8'h1F);
        end
        chk("busy_seen", DOUT[7], 1'b1);
        BUSY = 1'b0;
        tick();
        tick();
        chk("busy_low", DOUT[7], 1'b0);

        // Reset while HALTED and mid cancel pulse
        wr_reg(8'hC0);
        tick();
        idle();
        SHALTACn = 1'b0;
        for (int e = 0; e < 4; e++) tick();
        chk("pre_rst_gnt", SHRAM_GNT, 1'b1);
        chk("pre_rst_cn", CANCELn, 1'b0);
        #2 RESET = 1'b1;
        #1;
        chk("arst_shn", SUBHALTREQn, 1'b1);
        chk("arst_cn", CANCELn, 1'b1);
        chk("arst_gnt", SHRAM_GNT, 1'b0);
        SHALTACn = 1'b1;
        tick();
        #3 RESET = 1'b0;
        for (int e = 0; e < 12; e++) begin
            tick();
            chk("post_rst_shn", SUBHALTREQn, 1'b1);
            chk("post_rst_cn", CANCELn, 1'b1);
            chk("post_rst_gnt", SHRAM_GNT, 1'b0);
        end

        // Randomized cancel writes, reads and BUSY vs time-window model
        last_start = -1000;
        bprev = 1'b0;
        for (int k = 0; k < 400; k++) begin
            CS_FD05 = 1'($urandom_range(0, 1));
            RW = 1'($urandom_range(0, 1));
            WR_STB = CS_FD05 && !RW && ($urandom_range(0, 2) == 0);
            DIN = 8'($urandom) & 8'h7F;
            BUSY = 1'($urandom_range(0, 1));
            trig = CS_FD05 && !RW && WR_STB && DIN[6];
            if (trig && !((k - 1) >= last_start &&
                          (k - 1) < last_start + LEN))
                last_start = k;
            exp7 = bprev;
            bprev = BUSY;
            tick();
            exp_cn = !(k >= last_start && k < last_start + LEN);
            chk("rnd_cn", CANCELn, exp_cn);
            chk("rnd_dout", DOUT, {exp7, 1'b0, 5'b11111, 1'b0});
            chk("rnd_shn", SUBHALTREQn, 1'b1);
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/main_sub_if.md
MAIN_SUB_IF -- requirements
Module: main_sub_if

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- CANCEL_LEN, 8, CANCELn low-pulse width in CLK cycles (range 2..255).
- ACK_TIMEOUT, 4095, CLK cycles to wait for a halt acknowledge before flagging an error (range 1..65535).

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning; the clock and reset come first.
- CLK, in, 1: the single clock; every register is clocked on its rising edge.
- RESET, in, 1: asynchronous, active-high reset.
- CS_FD05, in, 1: main-CPU register select, active high.
- RW, in, 1: 1 = read, 0 = write.
- WR_STB, in, 1: single-cycle write strobe; valid when CS_FD05=1 and RW=0.
- DIN, in, 8: main-CPU write data.
- DOUT, out, 8: read data for the $FD05 register.
- SHALTACn, in, 1: sub-CPU halt acknowledge, asynchronous, active low.
- BUSY, in, 1: sub-CPU busy flag, asynchronous.
- SUBHALTREQn, out, 1: halt request to the sub-CPU, active low.
- CANCELn, out, 1: cancel/IRQ pulse to the sub-CPU; the sub side acts on the rising edge.
- SHRAM_GNT, out, 1: main CPU granted the shared sub-CPU RAM.
- ACK_ERR, out, 1: sticky halt-acknowledge timeout flag.

Function
REQ-003 SHALTACn and BUSY SHALL each pass through a 2-flop synchronizer before use; all latency figures below are counted from the synchronized value.
REQ-004 The block SHALL write DIN[7] to a HALT_WANT register and DIN[6] to a CANCEL trigger on a CLK edge where WR_STB=1 and CS_FD05=1; DIN[5:0] SHALL be ignored.
REQ-005 The halt FSM SHALL have exactly four states: RUN, REQ, HALTED, REL.
REQ-006 RUN: SUBHALTREQn=1 and SHRAM_GNT=0; the FSM SHALL go to REQ on the cycle after HALT_WANT becomes 1.
REQ-007 REQ: SUBHALTREQn=0 and the timeout counter runs.
- Synchronized SHALTACn=0 SHALL move the FSM to HALTED.
- HALT_WANT=0 SHALL move the FSM to REL.
- The counter reaching ACK_TIMEOUT SHALL set ACK_ERR and move the FSM to REL.
REQ-008 HALTED: SUBHALTREQn=0 and SHRAM_GNT=1; HALT_WANT=0 SHALL move the FSM to REL and drop SHRAM_GNT in that same transition.
REQ-009 REL: SUBHALTREQn=1; the FSM SHALL return to RUN when synchronized SHALTACn=1.
REQ-010 When HALT_WANT is written back to 1 while the FSM is in REL, the FSM SHALL complete REL->RUN and then re-enter REQ.
REQ-011 The timeout counter SHALL be 16 bits wide, saturating, and cleared on every entry to REQ.
REQ-012 A CANCEL trigger SHALL drive CANCELn low for exactly CANCEL_LEN cycles, starting the cycle after the write.
REQ-013 A CANCEL trigger that arrives while a pulse is active SHALL be ignored and SHALL NOT extend the pulse.
REQ-014 CANCEL and halt SHALL operate independently; a single write carrying both bits set SHALL perform both actions.
REQ-015 DOUT SHALL be combinational from registered state, with the following bit layout:
- DOUT[7] = synchronized BUSY.
- DOUT[6] = ACK_ERR.
- DOUT[5:1] = 5'b11111.
- DOUT[0] = 1 if the FSM is in HALTED.
REQ-016 A read with CS_FD05=1 and RW=1 SHALL clear ACK_ERR on the following edge, unless a new timeout occurs on that same edge, in which case set SHALL win.

Reset
REQ-017 RESET=1 SHALL asynchronously force the following values:
- FSM = RUN; HALT_WANT = 0; counters = 0; synchronizers = idle (SHALTACn sync = 1, BUSY sync = 0).
- SUBHALTREQn = 1, CANCELn = 1, SHRAM_GNT = 0, ACK_ERR = 0.
REQ-018 A reset asserted during a cancel pulse or during HALTED SHALL end it immediately; no residual pulse or grant SHALL follow reset release.

Structure
REQ-019 The FSM state encoding and the DOUT constant bits SHALL live in a shared package, fm7_subif_pkg.
REQ-020 The pulse generator SHALL be one sub-module, pulse_stretch, parameterized by CANCEL_LEN; everything else SHALL be flat.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Write 0x80, sub asserts SHALTACn=0 after 10 cycles -> SUBHALTREQn=0 starting at cycle 1; SHRAM_GNT=1 within 3 cycles of the ack; read DOUT[0]=1.
- From HALTED, write 0x00 -> SHRAM_GNT=0 the next cycle, SUBHALTREQn=1; FSM reaches RUN 3 cycles after SHALTACn returns to 1.
- Write 0x80 with SHALTACn held at 1, ACK_TIMEOUT=20 -> ACK_ERR=1 at cycle 21, FSM in REL; read DOUT=0x7E (BUSY=0) and ACK_ERR=0 afterwards.
- Write 0x40 twice, 3 cycles apart, CANCEL_LEN=8 -> exactly one low pulse on CANCELn, 8 cycles long.
- BUSY toggled 0->1 -> DOUT[7]=1 no later than 2 cycles after the toggle; DOUT[5:1]=11111 throughout.
- RESET pulsed mid-HALTED and mid-cancel-pulse -> SUBHALTREQn=1, CANCELn=1, SHRAM_GNT=0 with no clock edge required.
